// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared types and constants for the I2S record-path receiver.
package codec_rx_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    WAIT
  } i2s_rx_state_t;

  // Width of one channel lane inside the 64-bit stream beat
  localparam int LANE_WIDTH = 32;

  // Justification encodings
  localparam logic JUST_I2S  = 1'b0;
  localparam logic JUST_LEFT = 1'b1;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// AXI4-Stream master channel carrying one stereo pair per beat.
interface i2s_rx_deserializer_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/i2s_rx_deserializer_sync.sv
// Brings the codec-driven I2S pins into the AXI clock domain and flags bclk rises.
module i2s_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_bclk,
  input  logic i_lrc,
  input  logic i_dat,
  output logic o_bclkRise,
  output logic o_lrc,
  output logic o_dat
);

  logic [1:0] r_bclkSync;
  logic [1:0] r_lrcSync;
  logic [1:0] r_datSync;
  logic       r_bclkPrev;

  // Two-stage synchronizers for all three pins plus a delayed bclk copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclkSync <= '0;
      r_lrcSync  <= '0;
      r_datSync  <= '0;
      r_bclkPrev <= 1'b0;
    end else begin
      r_bclkSync <= {r_bclkSync[0], i_bclk};
      r_lrcSync  <= {r_lrcSync[0], i_lrc};
      r_datSync  <= {r_datSync[0], i_dat};
      r_bclkPrev <= r_bclkSync[1];
    end
  end

  assign o_bclkRise = r_bclkSync[1] & ~r_bclkPrev;
  assign o_lrc      = r_lrcSync[1];
  assign o_dat      = r_datSync[1];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S record-path receiver: deserializes left/right samples and emits one
// 64-bit AXI4-Stream beat per complete stereo pair.
module i2s_rx_deserializer
  import codec_rx_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int PACKET_FRAMES = 256
) (
  input  logic                  axi_clk,
  input  logic                  axis_aresetn,
  input  logic                  enable,
  input  logic                  justification,
  input  logic                  status_clear,
  input  logic                  ac_bclk,
  input  logic                  ac_reclrc,
  input  logic                  ac_recdat,
  i2s_rx_deserializer_if.master m_axis,
  output logic                  overflow,
  output logic                  frame_error,
  output logic [31:0]           wr_frame_count
);

  localparam int SR_W  = SAMPLE_WIDTH - 1;
  localparam int CNT_W = $clog2(SAMPLE_WIDTH);
  localparam int PKT_W = $clog2(PACKET_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SAMPLE_WIDTH - 1);
  localparam logic [PKT_W-1:0] LAST_BEAT = PKT_W'(PACKET_FRAMES - 1);

  logic w_bclkRise;
  logic w_lrc;
  logic w_dat;
  logic w_lrEdge;
  logic w_startChannel;
  logic w_shortChannel;
  logic [SAMPLE_WIDTH-1:0] w_shiftNext;
  logic [LANE_WIDTH-1:0]   w_laneLeft;
  logic [LANE_WIDTH-1:0]   w_laneRight;
  logic                    w_accept;
  logic [PKT_W-1:0]        w_pktCountNext;

  i2s_rx_state_t           r_state;
  logic                    r_lrcPrev;
  logic                    r_channel;
  logic [SR_W-1:0]         r_shiftReg;
  logic [CNT_W-1:0]        r_bitCount;
  logic [SAMPLE_WIDTH-1:0] r_leftSample;
  logic [SAMPLE_WIDTH-1:0] r_rightSample;
  logic                    r_leftValid;
  logic                    r_frameDone;
  logic                    r_frameError;
  logic                    r_tvalid;
  logic [2*LANE_WIDTH-1:0] r_tdata;
  logic                    r_tlast;
  logic                    r_overflow;
  logic [PKT_W-1:0]        r_pktCount;
  logic [31:0]             r_wrCount;

  i2s_input_sync u_sync (
    .clk        (axi_clk),
    .rst_n      (axis_aresetn),
    .i_bclk     (ac_bclk),
    .i_lrc      (ac_reclrc),
    .i_dat      (ac_recdat),
    .o_bclkRise (w_bclkRise),
    .o_lrc      (w_lrc),
    .o_dat      (w_dat)
  );

  assign w_lrEdge       = w_bclkRise && (w_lrc != r_lrcPrev);
  assign w_startChannel = w_lrEdge && ((r_state != IDLE) || (w_lrc == 1'b0));
  assign w_shortChannel = (r_state == SKIP) || (r_state == SHIFT);
  assign w_shiftNext    = {r_shiftReg, w_dat};
  assign w_laneLeft     = LANE_WIDTH'(r_leftSample);
  assign w_laneRight    = LANE_WIDTH'(r_rightSample);

  // Receive FSM: channel framing, bit shifting, channel latches and frame-error flag
  always_ff @(posedge axi_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state       <= IDLE;
      r_lrcPrev     <= 1'b0;
      r_channel     <= 1'b0;
      r_shiftReg    <= '0;
      r_bitCount    <= '0;
      r_leftSample  <= '0;
      r_rightSample <= '0;
      r_leftValid   <= 1'b0;
      r_frameDone   <= 1'b0;
      r_frameError  <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_bclkRise) begin
        r_lrcPrev <= w_lrc;
      end
      if (status_clear) begin
        r_frameError <= 1'b0;
      end
      if (!enable) begin
        r_state     <= IDLE;
        r_leftValid <= 1'b0;
      end else if (w_startChannel) begin
        if (w_shortChannel) begin
          r_frameError <= 1'b1;
        end
        if (w_shortChannel || (w_lrc == 1'b0)) begin
          r_leftValid <= 1'b0;
        end
        r_channel <= w_lrc;
        if (justification == JUST_I2S) begin
          r_state    <= SKIP;
          r_bitCount <= '0;
        end else begin
          r_state    <= SHIFT;
          r_shiftReg <= SR_W'(w_dat);
          r_bitCount <= CNT_W'(1);
        end
      end else if (w_bclkRise) begin
        case (r_state)
          SKIP: begin
            r_state    <= SHIFT;
            r_shiftReg <= SR_W'(w_dat);
            r_bitCount <= CNT_W'(1);
          end
          SHIFT: begin
            r_shiftReg <= w_shiftNext[SR_W-1:0];
            r_bitCount <= r_bitCount + CNT_W'(1);
            if (r_bitCount == LAST_BIT) begin
              r_state <= WAIT;
              if (r_channel == 1'b0) begin
                r_leftSample <= w_shiftNext;
                r_leftValid  <= 1'b1;
              end else begin
                r_rightSample <= w_shiftNext;
                r_frameDone   <= r_leftValid;
                r_leftValid   <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign w_accept       = r_tvalid && m_axis.tready;
  assign w_pktCountNext = !w_accept ? r_pktCount :
                          (r_pktCount == LAST_BEAT) ? '0 : r_pktCount + PKT_W'(1);

  // Output beat register, packet/beat counters and the overflow flag
  always_ff @(posedge axi_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
      r_pktCount <= '0;
      r_wrCount  <= '0;
    end else begin
      r_pktCount <= w_pktCountNext;
      if (w_accept) begin
        r_wrCount <= r_wrCount + 32'd1;
      end
      if (r_frameDone && (!r_tvalid || m_axis.tready)) begin
        r_tvalid <= 1'b1;
        r_tdata  <= {w_laneRight, w_laneLeft};
        r_tlast  <= (w_pktCountNext == LAST_BEAT);
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
      end
      if (status_clear) begin
        r_overflow <= 1'b0;
      end
      if (r_frameDone && r_tvalid && !m_axis.tready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid  = r_tvalid;
  assign m_axis.tdata   = r_tdata;
  assign m_axis.tlast   = r_tlast;
  assign overflow       = r_overflow;
  assign frame_error    = r_frameError;
  assign wr_frame_count = r_wrCount;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for the I2S record receiver: 16-bit samples, 20 bclk slots
// per channel, bclk = axi_clk/32, four beats per packet.
module tb_i2s_rx_deserializer;

  typedef struct {
    logic        just;
    logic [15:0] left;
    logic [15:0] right;
    logic [63:0] expData;
    logic        expLast;
    int          expCount;
  } frameVec_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          riseCycle;
  } beat_t;

  logic        axi_clk;
  logic        axis_aresetn;
  logic        enable;
  logic        justification;
  logic        status_clear;
  logic        ac_bclk;
  logic        ac_reclrc;
  logic        ac_recdat;
  logic        overflow;
  logic        frame_error;
  logic [31:0] wr_frame_count;

  int    cycleCnt = 0;
  int    lsbCycle = 0;
  int    riseCycle = 0;
  logic  prevValid = 1'b0;
  int    assertCount = 0;
  int    failCount = 0;
  beat_t beatQ[$];
  frameVec_t vecs[8];

  i2s_rx_deserializer_if m_axis_if ();

  i2s_rx_deserializer #(
    .SAMPLE_WIDTH  (16),
    .PACKET_FRAMES (4)
  ) dut (
    .axi_clk        (axi_clk),
    .axis_aresetn   (axis_aresetn),
    .enable         (enable),
    .justification  (justification),
    .status_clear   (status_clear),
    .ac_bclk        (ac_bclk),
    .ac_reclrc      (ac_reclrc),
    .ac_recdat      (ac_recdat),
    .m_axis         (m_axis_if.master),
    .overflow       (overflow),
    .frame_error    (frame_error),
    .wr_frame_count (wr_frame_count)
  );

  // Free-running clock and cycle counter used for latency measurement
  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  always @(posedge axi_clk) cycleCnt <= cycleCnt + 1;

  // Beat monitor: logs every accepted beat with the cycle its tvalid first rose
  always @(negedge axi_clk) begin
    if (m_axis_if.tvalid && !prevValid) riseCycle = cycleCnt;
    if (m_axis_if.tvalid && m_axis_if.tready)
      beatQ.push_back('{m_axis_if.tdata, m_axis_if.tlast, riseCycle});
    prevValid = m_axis_if.tvalid;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached, got no completion expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge axi_clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One I2S half-frame: lrc held for nSlots bclk periods, sample MSB-first
  task automatic sendHalf(input logic lrc, input logic [15:0] sample, input int nSlots, input bit markLsb);
    for (int k = 0; k < nSlots; k++) begin
      int   idx;
      logic bitVal;
      idx    = justification ? k : k - 1;
      bitVal = 1'b0;
      if (idx >= 0 && idx < 16) bitVal = sample[15 - idx];
      ac_bclk   = 1'b0;
      ac_reclrc = lrc;
      ac_recdat = bitVal;
      repeat (16) tick();
      ac_bclk = 1'b1;
      if (markLsb && idx == 15) lsbCycle = cycleCnt;
      repeat (16) tick();
    end
  endtask

  task automatic applyStimulus(input frameVec_t v, input bit forcePreamble);
    if (forcePreamble || v.just != justification) begin
      enable = 1'b0;
      repeat (4) tick();
      justification = v.just;
      enable = 1'b1;
      tick();
      sendHalf(1'b1, 16'h0000, 20, 1'b0);
    end
    sendHalf(1'b0, v.left, 20, 1'b0);
    sendHalf(1'b1, v.right, 20, 1'b1);
  endtask

  task automatic checkBeat(input string name, input logic [63:0] expData, input logic expLast);
    beat_t b;
    checkOutput({name, " beat count"}, 64'(beatQ.size()), 64'd1);
    if (beatQ.size() > 0) begin
      b = beatQ.pop_front();
      checkOutput({name, " tdata"}, b.data, expData);
      checkOutput({name, " tlast"}, 64'(b.last), 64'(expLast));
      checkOutput({name, " latency"}, 64'(b.riseCycle - lsbCycle), 64'd4);
    end
    beatQ.delete();
  endtask

  initial begin
    axis_aresetn = 1'b0;
    enable = 1'b0;
    justification = 1'b0;
    status_clear = 1'b0;
    ac_bclk = 1'b0;
    ac_reclrc = 1'b0;
    ac_recdat = 1'b0;
    m_axis_if.tready = 1'b1;

    vecs[0] = '{1'b0, 16'hA5C3, 16'h1234, 64'h0000_1234_0000_A5C3, 1'b0, 1};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 64'h0000_0001_0000_FFFF, 1'b0, 2};
    vecs[2] = '{1'b0, 16'h8000, 16'h7FFF, 64'h0000_7FFF_0000_8000, 1'b0, 3};
    vecs[3] = '{1'b0, 16'h0F0F, 16'hF0F0, 64'h0000_F0F0_0000_0F0F, 1'b1, 4};
    vecs[4] = '{1'b1, 16'hA5C3, 16'h1234, 64'h0000_1234_0000_A5C3, 1'b0, 5};
    vecs[5] = '{1'b1, 16'h0000, 16'hFFFF, 64'h0000_FFFF_0000_0000, 1'b0, 6};
    vecs[6] = '{1'b1, 16'h1357, 16'h9BDF, 64'h0000_9BDF_0000_1357, 1'b0, 7};
    vecs[7] = '{1'b1, 16'hC001, 16'h0003, 64'h0000_0003_0000_C001, 1'b1, 8};

    // Reset state
    repeat (4) tick();
    checkOutput("reset tvalid", 64'(m_axis_if.tvalid), 64'd0);
    checkOutput("reset tdata", m_axis_if.tdata, 64'd0);
    checkOutput("reset tlast", 64'(m_axis_if.tlast), 64'd0);
    checkOutput("reset overflow", 64'(overflow), 64'd0);
    checkOutput("reset frame_error", 64'(frame_error), 64'd0);
    checkOutput("reset wr_frame_count", 64'(wr_frame_count), 64'd0);
    axis_aresetn = 1'b1;
    tick();
    enable = 1'b1;
    tick();

    // Table of full frames in both justifications, including packet marking
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i == 0);
      checkBeat($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expLast);
      checkOutput($sformatf("vec%0d wr_frame_count", i), 64'(wr_frame_count), 64'(vecs[i].expCount));
    end

    // Backpressure: first beat held, second frame dropped
    m_axis_if.tready = 1'b0;
    sendHalf(1'b0, 16'h0001, 20, 1'b0);
    sendHalf(1'b1, 16'h0002, 20, 1'b0);
    checkOutput("bp held tvalid", 64'(m_axis_if.tvalid), 64'd1);
    checkOutput("bp held tdata", m_axis_if.tdata, 64'h0000_0002_0000_0001);
    sendHalf(1'b0, 16'h0003, 20, 1'b0);
    sendHalf(1'b1, 16'h0004, 20, 1'b0);
    checkOutput("bp stable tdata", m_axis_if.tdata, 64'h0000_0002_0000_0001);
    checkOutput("bp overflow", 64'(overflow), 64'd1);
    checkOutput("bp no accept", 64'(beatQ.size()), 64'd0);
    checkOutput("bp wr before ready", 64'(wr_frame_count), 64'd8);
    m_axis_if.tready = 1'b1;
    tick();
    tick();
    checkOutput("bp tvalid after accept", 64'(m_axis_if.tvalid), 64'd0);
    checkOutput("bp wr after ready", 64'(wr_frame_count), 64'd9);
    checkOutput("bp accepted count", 64'(beatQ.size()), 64'd1);
    if (beatQ.size() > 0) begin
      checkOutput("bp accepted tdata", beatQ[0].data, 64'h0000_0002_0000_0001);
      checkOutput("bp accepted tlast", 64'(beatQ[0].last), 64'd0);
    end
    beatQ.delete();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    checkOutput("bp overflow cleared", 64'(overflow), 64'd0);

    // Short right channel: error, no beat, then next full frame emits
    sendHalf(1'b0, 16'h00AA, 20, 1'b0);
    sendHalf(1'b1, 16'h0055, 10, 1'b0);
    sendHalf(1'b0, 16'h0BEE, 20, 1'b0);
    checkOutput("short frame_error", 64'(frame_error), 64'd1);
    checkOutput("short no beat", 64'(beatQ.size()), 64'd0);
    sendHalf(1'b1, 16'h0CAF, 20, 1'b1);
    checkBeat("short next", 64'h0000_0CAF_0000_0BEE, 1'b0);
    checkOutput("short wr_frame_count", 64'(wr_frame_count), 64'd10);
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    checkOutput("short frame_error cleared", 64'(frame_error), 64'd0);

    // Reset in the middle of a right channel
    sendHalf(1'b0, 16'h1111, 20, 1'b0);
    sendHalf(1'b1, 16'h2222, 8, 1'b0);
    axis_aresetn = 1'b0;
    repeat (3) tick();
    checkOutput("midrst tvalid", 64'(m_axis_if.tvalid), 64'd0);
    checkOutput("midrst tdata", m_axis_if.tdata, 64'd0);
    checkOutput("midrst wr_frame_count", 64'(wr_frame_count), 64'd0);
    checkOutput("midrst overflow", 64'(overflow), 64'd0);
    axis_aresetn = 1'b1;
    tick();
    sendHalf(1'b1, 16'h2222, 12, 1'b0);
    checkOutput("midrst no beat", 64'(beatQ.size()), 64'd0);
    checkOutput("midrst idle tvalid", 64'(m_axis_if.tvalid), 64'd0);
    sendHalf(1'b0, 16'h3333, 20, 1'b0);
    sendHalf(1'b1, 16'h4444, 20, 1'b1);
    checkBeat("midrst next", 64'h0000_4444_0000_3333, 1'b0);
    checkOutput("midrst wr after frame", 64'(wr_frame_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deserializer.md
# i2s_rx_deserializer

Record-path I2S receiver for the SSM2603 codec on the Zybo: it deserializes `ac_recdat` using the codec-driven `ac_bclk`/`ac_reclrc` and presents each stereo pair as one 64-bit AXI4-Stream beat toward the upstream (CODEC -> DMA) FIFO. It runs entirely in the AXI clock domain, oversampling the I2S pins through synchronizers. It is the receive counterpart of the playback serializer in the audio unit.

## Interface
- `SAMPLE_WIDTH`, 16: bits captured per channel, 8..32.
- `PACKET_FRAMES`, 256: accepted beats per packet; `m_axis_tlast` marks the last beat of each packet.
- `axi_clk` in 1: sole clock; must be at least 8x `ac_bclk`.
- `axis_aresetn` in 1: asynchronous, active-low reset.
- `enable` in 1: receiver on; low forces IDLE.
- `justification` in 1: 0 = I2S (1-bit delay), 1 = left-justified; static while `enable`=1.
- `status_clear` in 1: one-cycle pulse; clears sticky flags.
- `ac_bclk` in 1: I2S bit clock, asynchronous.
- `ac_reclrc` in 1: record LR clock, asynchronous; 0 = left, 1 = right.
- `ac_recdat` in 1: record serial data, MSB first, asynchronous.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tdata` out 64: `{zero-pad, right, zero-pad, left}`; each 32-bit lane holds its sample right-aligned with zeros above.
- `m_axis_tlast` out 1: last beat of a packet.
- `overflow` out 1: sticky; a completed frame was dropped.
- `frame_error` out 1: sticky; a channel was shorter than `SAMPLE_WIDTH`.
- `wr_frame_count` out 32: beats accepted; wraps at 2^32.

## Operation
- **Synchronization:**
  - `ac_bclk`, `ac_reclrc` and `ac_recdat` each pass through 2-FF synchronizers.
  - A bclk rise is detected as synchronized `prev==0 && cur==1`.
  - At each rise, `lrc` and `dat` are sampled; `lrc_prev` holds `lrc` from the previous rise.
  - An LR edge is a rise where `lrc != lrc_prev`.
- **FSM states:**
  - **IDLE:** wait for an LR edge with new `lrc`=0 (left start); go to SKIP if `justification`=0, else SHIFT and capture the current bit as MSB.
  - **SKIP:** the next rise goes to SHIFT and captures the MSB.
  - **SHIFT:** shift one bit per rise; after `SAMPLE_WIDTH` bits, latch the channel and go to WAIT.
  - **WAIT:** ignore surplus bits until an LR edge.
- **LR edge handling (SKIP/SHIFT/WAIT):**
  - Start the new channel (SKIP or SHIFT, as above).
  - If the edge arrives in SKIP or SHIFT with fewer than `SAMPLE_WIDTH` bits captured: set `frame_error`, discard the pair in progress, and do not emit until the next left channel.
- **Frame completion:**
  - The right-channel latch completes a frame only if the left channel of the same pair was valid.
  - If the output register is empty, or being accepted this cycle, load it and assert `tvalid`.
  - Otherwise drop the new frame, set `overflow`, and leave the held beat unchanged.
- **Output hold:** `tdata`/`tlast` are stable while `tvalid && !tready`. A beat is accepted on `tvalid && tready`.
- **Packet counting:**
  - The packet counter counts accepted beats only; dropped frames are not counted.
  - `tlast` = (counter == `PACKET_FRAMES`-1); the counter wraps to 0 after the tlast beat.
  - `wr_frame_count` increments on acceptance.
- **Enable:** `enable`=0 returns the FSM to IDLE the next cycle and discards any partial frame. A pending output beat is still delivered normally.
- **Status clear:** `status_clear` clears both sticky flags. If it coincides with a new error, the set wins.

## Timing
- **Reset values:** all outputs 0 (`tvalid`, `tdata`, `tlast`, `overflow`, `frame_error`, `wr_frame_count`). FSM resets to IDLE; synchronizers and counters reset to 0.
- **Latency:** `tvalid` rises exactly 4 `axi_clk` cycles after the pin-level bclk rise carrying the right-channel LSB, given ideal setup. Asynchronous skew adds ≤1 cycle.
- **Throughput:** at most one beat per LR period; no bubbles required between accepted beats.
- **Simultaneous load and accept:** when `tvalid && tready` coincides with a new frame load, the register reloads with no dead cycle and no overflow.
- **Reset mid-frame:** the reset is asynchronous. After release, the first beat requires a full left channel starting at an LR falling edge.

## Structure
- **Package `codec_rx_pkg`:**
  - `i2s_rx_state_t` enum (IDLE, SKIP, SHIFT, WAIT).
  - `LANE_WIDTH`=32.
  - Justification encodings `JUST_I2S`=0, `JUST_LEFT`=1.
- **Sub-module `i2s_input_sync`:** 2-FF synchronizers for the three pins plus the bclk rise-detect output.
- Everything else (FSM, shift register, channel latches, output register, counters) lives in the top.

## Test plan
- **I2S mode:** `SAMPLE_WIDTH`=16, bclk = `axi_clk`/32, left 16'hA5C3, right 16'h1234, `tready`=1 -> one beat `tdata`=64'h0000_1234_0000_A5C3, `tvalid` high one cycle, 4-cycle latency.
- **Left-justified:** same stimulus with `justification`=1 and data shifted one bit earlier -> identical beat.
- **Backpressure:** `tready`=0 across 2 frames (L/R 1/2, 3/4) -> beat 64'h0000_0002_0000_0001 held stable; second frame dropped; `overflow`=1; after `tready`=1, `wr_frame_count`=1; `status_clear` -> `overflow`=0.
- **Short channel:** LR toggles after 10 right-channel bits -> `frame_error`=1, no beat; the following full frame emits normally.
- **Packet marking:** `PACKET_FRAMES`=4, 8 frames with `tready`=1 -> `tlast` on beats 4 and 8 only; `wr_frame_count`=8.
- **Reset mid-frame:** `axis_aresetn` low during the right-channel bits -> all outputs 0; after release, no beat until a complete frame following an LR falling edge.
